// File: rtl/decoder_skid_2to4_if.sv
// rtl/decoder_skid_2to4_if.sv - handshake and status bundle for the 2-to-4 decoder skid buffer
interface decoder_skid_2to4_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       in_code;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       out_onehot;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] dec_count;
   logic [1:0]       occupancy;

   modport slave (
      input  in_code, in_valid, out_ready,
      output in_ready, out_onehot, out_valid, dec_count, occupancy
   );

   modport master (
      output in_code, in_valid, out_ready,
      input  in_ready, out_onehot, out_valid, dec_count, occupancy
   );
endinterface

// File: rtl/decoder_skid_2to4.sv
// rtl/decoder_skid_2to4.sv - 2-to-4 one-hot decoder feeding a registered 2-entry FIFO
module decoder_skid_2to4 #(
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   decoder_skid_2to4_if.slave  bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       head_q, head_d;
   logic [3:0]       tail_q, tail_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       dec_word;
   logic             push, pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= 4'b0000;
         tail_q     <= 4'b0000;
         in_ready_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
         count_q    <= count_d;
      end
   end

   // in_ready_q is low in FULL, so a push can never reach a full buffer
   always_comb begin
      dec_word   = 4'b0001 << bus.in_code;
      push       = bus.in_valid && in_ready_q;
      pop        = (state_q != EMPTY) && bus.out_ready;
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = dec_word;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d  = dec_word;
            end else if (push) begin
               state_d = FULL;
               tail_d  = dec_word;
            end else if (pop) begin
               state_d = EMPTY;
               head_d  = 4'b0000;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: begin
            state_d = EMPTY;
            head_d  = 4'b0000;
         end
      endcase
      if (pop) begin
         count_d = count_q + CNT_W'(1);
      end
      in_ready_d = (state_d != FULL);
   end

   // head_q is cleared whenever the buffer drains, so it doubles as the zeroed idle output
   always_comb begin
      bus.out_onehot = head_q;
      bus.out_valid  = (state_q != EMPTY);
      bus.in_ready   = in_ready_q;
      bus.dec_count  = count_q;
      case (state_q)
         ONE:     bus.occupancy = 2'd1;
         FULL:    bus.occupancy = 2'd2;
         default: bus.occupancy = 2'd0;
      endcase
   end
endmodule
